// File: rtl/mac_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mac_pkg
// Purpose  : Shared state encoding, default sizes and lane-width helper for
//            the MAC accumulation stage.
// Revision : 1.0 - initial release
// ============================================================================
package mac_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEF_ACC_W     = 32;
    localparam int DEF_MAX_TERMS = 256;

    function automatic int lane_width(input int acc_w);
        return acc_w / 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mac_accumulator_acc_lane_add.sv
`default_nettype none
// ============================================================================
// Module   : acc_lane_add
// Purpose  : Extend an IN_W-bit addend to W bits, add it to an accumulator and
//            flag overflow; clamps on overflow when ACC_SATURATE_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module acc_lane_add #(
    parameter int W    = 16,
    parameter int IN_W = 8
) (
    input  logic [W-1:0]    acc,
    input  logic [IN_W-1:0] addend,
    input  logic            is_signed,
    output logic [W-1:0]    sum,
    output logic            ovf
);

    logic [W-1:0] w_ext;
    logic [W:0]   w_full;
    logic         w_ovf_s;
    logic         w_ovf_u;

    assign w_ext   = {{(W-IN_W){is_signed & addend[IN_W-1]}}, addend};
    assign w_full  = {1'b0, acc} + {1'b0, w_ext};
    assign w_ovf_u = w_full[W];
    // Signed overflow: operands agree in sign but the result does not.
    assign w_ovf_s = (acc[W-1] == w_ext[W-1]) && (w_full[W-1] != acc[W-1]);
    assign ovf     = is_signed ? w_ovf_s : w_ovf_u;

`ifdef ACC_SATURATE_EN
    always_comb begin
        sum = w_full[W-1:0];
        if (ovf) begin
            if (is_signed) begin
                sum = acc[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
            end else begin
                sum = '1;
            end
        end
    end
`else
    assign sum = w_full[W-1:0];
`endif

endmodule
`default_nettype wire

// File: rtl/mac_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : mac_accumulator
// Purpose  : Dot-product accumulator behind the 8-bit multiplier, scalar or
//            dual-lane vector mode, valid/ready in and out. ACC_SATURATE_EN
//            selects clamping instead of wrap-around on overflow.
// Revision : 1.0 - initial release
// ============================================================================
module mac_accumulator
    import mac_pkg::*;
#(
    parameter int ACC_W     = DEF_ACC_W,
    parameter int MAX_TERMS = DEF_MAX_TERMS,
    localparam int LANE_W   = lane_width(ACC_W),
    localparam int CNT_W    = $clog2(MAX_TERMS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_y,
    input  logic             in_s,
    input  logic             in_v,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_v,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf
);

    state_t             r_state, w_state_nxt;
    logic [ACC_W-1:0]   r_acc,   w_acc_nxt;
    logic [CNT_W-1:0]   r_count, w_count_nxt;
    logic               r_ovf,   w_ovf_nxt;
    logic               r_v,     w_v_nxt;
    logic               r_s,     w_s_nxt;

    logic               w_idle;
    logic               w_accept;
    logic               w_mode_s;
    logic               w_mode_v;
    logic [ACC_W-1:0]   w_base;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic               w_ovf_base;
    logic [ACC_W-1:0]   w_sum_sc;
    logic [LANE_W-1:0]  w_sum_l1;
    logic [LANE_W-1:0]  w_sum_l0;
    logic               w_ovf_sc;
    logic               w_ovf_l1;
    logic               w_ovf_l0;

    assign in_ready = !rst && (r_state != DONE);
    assign w_accept = in_valid && in_ready;

    // The first beat of a dot product fixes the mode and starts from zero.
    assign w_idle     = (r_state == IDLE);
    assign w_mode_s   = w_idle ? in_s : r_s;
    assign w_mode_v   = w_idle ? in_v : r_v;
    assign w_base     = w_idle ? '0 : r_acc;
    assign w_cnt_inc  = (w_idle ? '0 : r_count) + CNT_W'(1);
    assign w_ovf_base = w_idle ? 1'b0 : r_ovf;

    acc_lane_add #(.W(ACC_W), .IN_W(16)) u_add_scalar (
        .acc       (w_base),
        .addend    (in_y),
        .is_signed (w_mode_s),
        .sum       (w_sum_sc),
        .ovf       (w_ovf_sc)
    );

    acc_lane_add #(.W(LANE_W), .IN_W(8)) u_add_lane1 (
        .acc       (w_base[ACC_W-1:LANE_W]),
        .addend    (in_y[15:8]),
        .is_signed (w_mode_s),
        .sum       (w_sum_l1),
        .ovf       (w_ovf_l1)
    );

    acc_lane_add #(.W(LANE_W), .IN_W(8)) u_add_lane0 (
        .acc       (w_base[LANE_W-1:0]),
        .addend    (in_y[7:0]),
        .is_signed (w_mode_s),
        .sum       (w_sum_l0),
        .ovf       (w_ovf_l0)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_count_nxt = r_count;
        w_ovf_nxt   = r_ovf;
        w_v_nxt     = r_v;
        w_s_nxt     = r_s;
        case (r_state)
            IDLE, ACCUM: begin
                if (w_accept) begin
                    w_acc_nxt   = w_mode_v ? {w_sum_l1, w_sum_l0} : w_sum_sc;
                    w_ovf_nxt   = w_ovf_base | (w_mode_v ? (w_ovf_l1 | w_ovf_l0) : w_ovf_sc);
                    w_count_nxt = w_cnt_inc;
                    w_s_nxt     = w_mode_s;
                    w_v_nxt     = w_mode_v;
                    w_state_nxt = (in_last || (w_cnt_inc == CNT_W'(MAX_TERMS))) ? DONE : ACCUM;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_nxt = IDLE;
                    w_acc_nxt   = '0;
                    w_count_nxt = '0;
                    w_ovf_nxt   = 1'b0;
                    w_v_nxt     = 1'b0;
                    w_s_nxt     = 1'b0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_v     <= 1'b0;
            r_s     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_count <= w_count_nxt;
            r_ovf   <= w_ovf_nxt;
            r_v     <= w_v_nxt;
            r_s     <= w_s_nxt;
        end
    end

    assign out_valid = (r_state == DONE);
    assign out_acc   = r_acc;
    assign out_count = r_count;
    assign out_ovf   = r_ovf;
    assign out_v     = r_v;

endmodule
`default_nettype wire

// File: tb/tb_mac_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_mac_accumulator
// Purpose  : Three accumulator configurations driven by one shared stimulus
//            stream, each checked every cycle against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mac_accumulator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] in_y = '0;
    logic        in_s = 1'b0;
    logic        in_v = 1'b0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b0;

    always #5 clk = ~clk;

    // dut0: 32-bit/256 terms, dut1: 24-bit/32 terms, dut2: 32-bit/4 terms
    logic        ir0, ov0, v0, ovf0;
    logic [31:0] acc0;
    logic [8:0]  cnt0;
    logic        ir1, ov1, v1, ovf1;
    logic [23:0] acc1;
    logic [5:0]  cnt1;
    logic        ir2, ov2, v2, ovf2;
    logic [31:0] acc2;
    logic [2:0]  cnt2;

    mac_accumulator #(.ACC_W(32), .MAX_TERMS(256)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir0), .in_y(in_y),
        .in_s(in_s), .in_v(in_v), .in_last(in_last), .out_valid(ov0),
        .out_ready(out_ready), .out_acc(acc0), .out_v(v0), .out_count(cnt0), .out_ovf(ovf0));
    mac_accumulator #(.ACC_W(24), .MAX_TERMS(32)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1), .in_y(in_y),
        .in_s(in_s), .in_v(in_v), .in_last(in_last), .out_valid(ov1),
        .out_ready(out_ready), .out_acc(acc1), .out_v(v1), .out_count(cnt1), .out_ovf(ovf1));
    mac_accumulator #(.ACC_W(32), .MAX_TERMS(4)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir2), .in_y(in_y),
        .in_s(in_s), .in_v(in_v), .in_last(in_last), .out_valid(ov2),
        .out_ready(out_ready), .out_acc(acc2), .out_v(v2), .out_count(cnt2), .out_ovf(ovf2));

    logic [31:0] d_acc [3];
    logic [8:0]  d_cnt [3];
    logic        d_ir  [3];
    logic        d_ov  [3];
    logic        d_v   [3];
    logic        d_ovf [3];
    assign d_acc[0] = acc0;  assign d_acc[1] = {8'd0, acc1}; assign d_acc[2] = acc2;
    assign d_cnt[0] = cnt0;  assign d_cnt[1] = {3'd0, cnt1}; assign d_cnt[2] = {6'd0, cnt2};
    assign d_ir[0]  = ir0;   assign d_ir[1]  = ir1;          assign d_ir[2]  = ir2;
    assign d_ov[0]  = ov0;   assign d_ov[1]  = ov1;          assign d_ov[2]  = ov2;
    assign d_v[0]   = v0;    assign d_v[1]   = v1;           assign d_v[2]   = v2;
    assign d_ovf[0] = ovf0;  assign d_ovf[1] = ovf1;         assign d_ovf[2] = ovf2;

    int P_W [3] = '{32, 24, 32};
    int P_M [3] = '{256, 32, 4};

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Model: sums kept as mathematical integers, range-checked per mode.
    bit     m_done [3];
    int     m_cnt  [3];
    bit     m_ovf  [3];
    bit     m_v    [3];
    bit     m_s    [3];
    longint m_sc   [3];
    longint m_l1   [3];
    longint m_l0   [3];

    function automatic longint ext(input logic [15:0] y, input int n, input bit sgn);
        longint one = 1;
        longint u = (n == 8) ? longint'(y[7:0]) : longint'(y);
        if (sgn && u >= (one << (n - 1))) u = u - (one << n);
        return u;
    endfunction

    function automatic longint addv(input longint cur, input longint a, input int w,
                                    input bit sgn, output bit o);
        longint one = 1;
        longint lo  = sgn ? -(one << (w - 1)) : 0;
        longint hi  = sgn ? (one << (w - 1)) - 1 : (one << w) - 1;
        longint t   = cur + a;
        o = 1'b0;
        if (t < lo || t > hi) begin
            o = 1'b1;
`ifdef ACC_SATURATE_EN
            t = (t > hi) ? hi : lo;
`else
            t = t & ((one << w) - 1);
            if (sgn && t > hi) t = t - (one << w);
`endif
        end
        return t;
    endfunction

    function automatic logic [31:0] exp_acc(input int i);
        longint one = 1;
        int     lw  = P_W[i] / 2;
        longint ml  = (one << lw) - 1;
        if (m_v[i]) return 32'(((m_l1[i] & ml) << lw) | (m_l0[i] & ml));
        return 32'(m_sc[i] & ((one << P_W[i]) - 1));
    endfunction

    task automatic clr(input int i);
        m_done[i] = 0; m_cnt[i] = 0; m_ovf[i] = 0; m_v[i] = 0; m_s[i] = 0;
        m_sc[i] = 0; m_l1[i] = 0; m_l0[i] = 0;
    endtask

    task automatic step(input int i);
        bit o1, o0;
        if (rst) begin
            clr(i);
        end else if (m_done[i]) begin
            if (out_ready) clr(i);
        end else if (in_valid) begin
            if (m_cnt[i] == 0) begin
                clr(i);
                m_s[i] = in_s;
                m_v[i] = in_v;
            end
            if (m_v[i]) begin
                m_l1[i] = addv(m_l1[i], ext({8'd0, in_y[15:8]}, 8, m_s[i]), P_W[i] / 2, m_s[i], o1);
                m_l0[i] = addv(m_l0[i], ext(in_y, 8, m_s[i]), P_W[i] / 2, m_s[i], o0);
            end else begin
                m_sc[i] = addv(m_sc[i], ext(in_y, 16, m_s[i]), P_W[i], m_s[i], o1);
                o0 = 1'b0;
            end
            m_ovf[i] = m_ovf[i] | o1 | o0;
            m_cnt[i] = m_cnt[i] + 1;
            if (in_last || m_cnt[i] == P_M[i]) m_done[i] = 1;
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) clr(i);
        forever begin
            @(posedge clk);
            for (int i = 0; i < 3; i++) step(i);
        end
    end

    initial begin
        @(posedge clk);
        forever begin
            #1;
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("dut%0d in_ready", i),  64'(d_ir[i]),  64'(!rst && !m_done[i]));
                chk($sformatf("dut%0d out_valid", i), 64'(d_ov[i]),  64'(m_done[i]));
                chk($sformatf("dut%0d out_acc", i),   64'(d_acc[i]), 64'(exp_acc(i)));
                chk($sformatf("dut%0d out_count", i), 64'(d_cnt[i]), 64'(m_cnt[i]));
                chk($sformatf("dut%0d out_ovf", i),   64'(d_ovf[i]), 64'(m_ovf[i]));
                chk($sformatf("dut%0d out_v", i),     64'(d_v[i]),   64'(m_v[i]));
            end
            @(posedge clk);
        end
    end

    task automatic drive(input bit v, input logic [15:0] y, input bit s, input bit vv,
                         input bit l, input bit ordy, input bit r);
        @(negedge clk);
        in_valid = v; in_y = y; in_s = s; in_v = vv; in_last = l;
        out_ready = ordy; rst = r;
    endtask

    task automatic idle(input bit ordy);
        drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, ordy, 1'b0);
    endtask

    task automatic reset_all();
        drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(1'b0);
    endtask

    logic [31:0] held;

    initial begin
        drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("reset out_valid", 64'(ov0), 64'd0);
        chk("reset out_acc",   64'(acc0), 64'd0);
        chk("reset out_count", 64'(cnt0), 64'd0);
        chk("reset in_ready",  64'(ir0), 64'd0);

        reset_all();
        drive(1'b1, 16'hFE01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(1'b0);
        chk("unsigned scalar acc",   64'(acc0), 64'h0000FE02);
        chk("unsigned scalar count", 64'(cnt0), 64'd2);
        chk("unsigned scalar ovf",   64'(ovf0), 64'd0);
        chk("unsigned scalar v",     64'(v0), 64'd0);
        chk("unsigned scalar valid", 64'(ov0), 64'd1);

        reset_all();
        drive(1'b1, 16'hFF81, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 16'h0001, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(1'b0);
        chk("signed scalar acc", 64'(acc0), 64'hFFFFFF82);

        reset_all();
        drive(1'b1, 16'h807F, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 16'h807F, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(1'b0);
        chk("signed vector acc", 64'(acc0), 64'hFF0000FE);
        chk("signed vector v",   64'(v0), 64'd1);

        reset_all();
        for (int k = 1; k <= 17; k++) drive(1'b1, 16'hFFFF, 1'b0, 1'b1, (k == 17), 1'b0, 1'b0);
        idle(1'b0);
`ifdef ACC_SATURATE_EN
        chk("overflow24 acc", 64'(acc1), 64'hFFFFFF);
`else
        chk("overflow24 acc", 64'(acc1), 64'h0EF0EF);
`endif
        chk("overflow24 ovf",  64'(ovf1), 64'd1);
        chk("no overflow32 acc", 64'(acc0), 64'h10EF10EF);

        held = acc0;
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b0, 1'b0);
            chk("backpressure valid", 64'(ov0), 64'd1);
            chk("backpressure acc",   64'(acc0), 64'(held));
            chk("backpressure ready", 64'(ir0), 64'd0);
        end
        chk("backpressure count", 64'(cnt0), 64'd17);
        idle(1'b1);
        idle(1'b1);
        chk("consume valid", 64'(ov0), 64'd0);
        chk("consume acc",   64'(acc0), 64'd0);

        reset_all();
        for (int k = 0; k < 3; k++) drive(1'b1, 16'h0010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 16'h0005, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("mid reset acc",   64'(acc0), 64'd0);
        chk("mid reset count", 64'(cnt0), 64'd0);
        idle(1'b0);
        chk("after reset acc",   64'(acc0), 64'd5);
        chk("after reset count", 64'(cnt0), 64'd1);
        chk("after reset valid", 64'(ov0), 64'd1);

        reset_all();
        for (int k = 0; k < 4; k++) drive(1'b1, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        chk("max terms valid", 64'(ov2), 64'd1);
        chk("max terms count", 64'(cnt2), 64'd4);
        chk("max terms acc",   64'(acc2), 64'd4);
        chk("not max valid",   64'(ov0), 64'd0);

        reset_all();
        for (int k = 0; k < 3000; k++) begin
            drive(($urandom_range(0, 9) < 7), 16'($urandom), 1'($urandom), 1'($urandom),
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) < 6),
                  ($urandom_range(0, 199) == 0));
        end
        idle(1'b1);
        idle(1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
